serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width in bits; the legal range is 1..32.
REQ-002 Port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port START, input, 1 bit: request to begin an addition; it is sampled only in IDLE.
REQ-005 Port A, input, WIDTH bits: operand A, captured on the START-accept edge.
REQ-006 Port B, input, WIDTH bits: operand B, captured on the START-accept edge.
REQ-007 Port CIN, input, 1 bit: carry-in, captured on the START-accept edge.
REQ-008 Port BUSY, output, 1 bit: high while the state is RUN.
REQ-009 Port DONE, output, 1 bit: a one-cycle pulse that marks a new result.
REQ-010 Port S, output, WIDTH bits: registered sum.
REQ-011 Port COUT, output, 1 bit: registered carry out of the MSB.

Function
REQ-012 The block SHALL sequence a single 1-bit full-adder cell over WIDTH cycles, processing the LSB first.
REQ-013 The FSM SHALL have the states IDLE, RUN and FIN, with transitions as follows.
- IDLE to RUN when START=1.
- RUN to FIN after WIDTH bit-cycles.
- FIN to IDLE unconditionally.
REQ-014 On the accept edge t0, the block SHALL load A, B and CIN into internal shift/carry registers and clear the bit counter.
REQ-015 On each edge t1..tWIDTH, the block SHALL add one bit pair plus the carry register.
- Each edge shifts the sum bit into the partial-sum register.
- Each edge updates the carry register.
- Each edge increments the counter.
REQ-016 On edge tWIDTH, the block SHALL copy the partial sum to S and the final carry to COUT, and enter FIN.
REQ-017 DONE SHALL be 1 only in the FIN cycle, which is exactly WIDTH+1 cycles after the START sample.
REQ-018 S and COUT SHALL change only at the completion edge and SHALL hold their value until the next completion.
REQ-019 START SHALL be ignored in RUN and FIN; operand changes after t0 SHALL NOT affect the result.
REQ-020 If START=1 in IDLE directly after FIN, a new operation SHALL begin; this gives a back-to-back throughput of one result per WIDTH+2 cycles.
REQ-021 The result SHALL equal A+B+CIN modulo 2^WIDTH, with COUT being bit WIDTH of the full sum.
REQ-022 When WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-023 While RST=1, the block SHALL immediately force the following, independent of CLK:
- state to IDLE;
- BUSY, DONE and COUT to 0, and S to all zeros;
- all internal registers and the counter to 0.
REQ-024 If RST is asserted mid-RUN, the block SHALL discard the operation with no DONE pulse; the first START after RST deasserts SHALL be accepted normally.

Configuration
REQ-025 The macro SERIAL_ADDER_SUB_EN SHALL add an input port SUB (1 bit), captured at t0.
- When SUB=1, the captured B SHALL be bitwise inverted and the carry-in forced to 1, so the result is A-B.
- When SUB=1, COUT=1 SHALL mean no borrow.
REQ-026 Without SERIAL_ADDER_SUB_EN, the SUB port and all its logic SHALL be absent, and behaviour SHALL be addition only.

Structure
REQ-027 The package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, FIN) and the default width constant.
REQ-028 The full-adder cell SHALL be a separate combinational sub-module, fa_bit, with these equations:
- s = a^b^cin;
- cout = (a&b) | (b&cin) | (a&cin).

Verification
REQ-029 With WIDTH=8, A=0x00, B=0x00, CIN=0 and START pulsed: S=0x00, COUT=0, BUSY high for 8 cycles, and DONE high in cycle 9 after START.
REQ-030 With A=0xFF, B=0x01, CIN=0: S=0x00, COUT=1. With A=0xA5, B=0x5A, CIN=1: S=0x00, COUT=1. With A=0x3C, B=0x42, CIN=0: S=0x7E, COUT=0.
REQ-031 With START held high for 20 cycles and A/B changed at cycle 3: the first result reflects the operands at t0; a second operation starts in the cycle after FIN; exactly two DONE pulses occur.
REQ-032 With RST asserted at bit-cycle 3 of an operation: outputs go to 0 asynchronously and no DONE pulse occurs; a following A=0x10, B=0x20 gives S=0x30.
REQ-033 With SERIAL_ADDER_SUB_EN defined and SUB=1: A=0x05, B=0x07 gives S=0xFE, COUT=0; A=0x07, B=0x05 gives S=0x02, COUT=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  // Wide enough to count bit-cycles for any legal WIDTH (1..32).
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// Single-bit combinational full-adder cell, reused once per bit-cycle.
module fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_b & i_cin) | (i_a & i_cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fa_bit cell stepped LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADDER_SUB_EN adds a SUB input for A-B.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic [1:0]       o_state
);

  // Handshake: START is a level request sampled only in IDLE; DONE is a
  // single-cycle pulse in FIN that qualifies a fresh S/COUT.

  localparam logic [WIDTH-1:0] MSB_MASK = ~({WIDTH{1'b1}} >> 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and inject a carry of 1.
  assign w_b_in = SUB ? ~B : B;
  assign w_c_in = SUB ? 1'b1 : CIN;
`else
  assign w_b_in = B;
  assign w_c_in = CIN;
`endif

  fa_bit u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_c),
    .o_s    (w_fa_s),
    .o_cout (w_fa_c)
  );

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign w_sum_next = (r_sum >> 1) | ({WIDTH{w_fa_s}} & MSB_MASK);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_a     <= A;
            r_b     <= w_b_in;
            r_c     <= w_c_in;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_fa_c;
          r_sum <= w_sum_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_s     <= w_sum_next;
            r_cout  <= w_fa_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign S       = r_s;
  assign COUT    = r_cout;
  assign o_state = r_state;

endmodule
